// File: rtl/pipelined_csa_addsub.sv
// Parametrised pipelined carry-select adder/subtractor with valid/ready handshake,
// unsigned carry and signed overflow flags, and optional signed saturation.
module pipelined_csa_addsub #(
    parameter int WIDTH       = 32,
    parameter int BLOCK       = 4,
    parameter int PIPE_BLOCKS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sat_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_out_o,
    output logic             ovf_o
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int L    = NBLK / PIPE_BLOCKS;

    logic [WIDTH-1:0] aQ [L];
    logic [WIDTH-1:0] xQ [L];
    logic [WIDTH-1:0] sumQ [L];
    logic             carryQ [L];
    logic             satQ [L];
    logic             validQ [L];
    logic             ovfQ;

    logic [WIDTH-1:0] aD [L];
    logic [WIDTH-1:0] xD [L];
    logic [WIDTH-1:0] sumD [L];
    logic             carryD [L];
    logic             satD [L];
    logic             validD [L];
    logic             ovfD;

    logic [WIDTH-1:0] stA [L];
    logic [WIDTH-1:0] stX [L];
    logic [WIDTH-1:0] stSum [L];
    logic             stC [L];
    logic             stSat [L];
    logic             stV [L];

    logic [BLOCK:0]   s0;
    logic [BLOCK:0]   s1;
    logic [BLOCK:0]   sel;
    logic             cRun;
    logic             advance;

    assign advance    = !validQ[L-1] || out_ready_i;
    assign in_ready_o = advance;

    // Stage 0 sees the prepared operands; later stages see the previous stage register.
    always_comb begin
        stA[0]   = a_i;
        stX[0]   = b_i ^ {WIDTH{sub_i}};
        stSum[0] = '0;
        stC[0]   = sub_i;
        stSat[0] = sat_i;
        stV[0]   = in_valid_i;
        for (int k = 1; k < L; k++) begin
            stA[k]   = aQ[k-1];
            stX[k]   = xQ[k-1];
            stSum[k] = sumQ[k-1];
            stC[k]   = carryQ[k-1];
            stSat[k] = satQ[k-1];
            stV[k]   = validQ[k-1];
        end
    end

    always_comb begin
        s0   = '0;
        s1   = '0;
        sel  = '0;
        cRun = 1'b0;
        ovfD = 1'b0;
        for (int k = 0; k < L; k++) begin
            aD[k]     = stA[k];
            xD[k]     = stX[k];
            sumD[k]   = stSum[k];
            satD[k]   = stSat[k];
            validD[k] = stV[k];
            cRun      = stC[k];
            for (int j = 0; j < PIPE_BLOCKS; j++) begin
                s0  = {1'b0, stA[k][(k*PIPE_BLOCKS+j)*BLOCK +: BLOCK]}
                    + {1'b0, stX[k][(k*PIPE_BLOCKS+j)*BLOCK +: BLOCK]};
                s1  = {1'b0, stA[k][(k*PIPE_BLOCKS+j)*BLOCK +: BLOCK]}
                    + {1'b0, stX[k][(k*PIPE_BLOCKS+j)*BLOCK +: BLOCK]}
                    + {{BLOCK{1'b0}}, 1'b1};
                sel = cRun ? s1 : s0;
                sumD[k][(k*PIPE_BLOCKS+j)*BLOCK +: BLOCK] = sel[BLOCK-1:0];
                cRun = sel[BLOCK];
            end
            carryD[k] = cRun;
        end
        // Same-sign operands producing an opposite-sign sum is exactly c[W] ^ c[W-1].
        ovfD = (stA[L-1][WIDTH-1] == stX[L-1][WIDTH-1])
            && (sumD[L-1][WIDTH-1] != stA[L-1][WIDTH-1]);
        if (stSat[L-1] && ovfD) begin
            sumD[L-1] = stA[L-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < L; k++) begin
                aQ[k]     <= '0;
                xQ[k]     <= '0;
                sumQ[k]   <= '0;
                carryQ[k] <= 1'b0;
                satQ[k]   <= 1'b0;
                validQ[k] <= 1'b0;
            end
            ovfQ <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < L; k++) begin
                aQ[k]     <= aD[k];
                xQ[k]     <= xD[k];
                sumQ[k]   <= sumD[k];
                carryQ[k] <= carryD[k];
                satQ[k]   <= satD[k];
                validQ[k] <= validD[k];
            end
            ovfQ <= ovfD;
        end
    end

    assign out_valid_o = validQ[L-1];
    assign y_o         = sumQ[L-1];
    assign carry_out_o = carryQ[L-1];
    assign ovf_o       = ovfQ;

endmodule

// File: tb/tb_pipelined_csa_addsub.sv
// Directed self-checking bench for pipelined_csa_addsub: default build plus a
// BLOCK=8 / PIPE_BLOCKS=1 build driven with identical inputs.
module tb_pipelined_csa_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic        outReady;

    logic        inReady,  inReady2;
    logic        outValid, outValid2;
    logic [31:0] y,        y2;
    logic        cOut,     cOut2;
    logic        ovf,      ovf2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_csa_addsub dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady),
        .a_i(a), .b_i(b), .sub_i(sub), .sat_i(sat),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .y_o(y), .carry_out_o(cOut), .ovf_o(ovf)
    );

    pipelined_csa_addsub #(.WIDTH(32), .BLOCK(8), .PIPE_BLOCKS(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady2),
        .a_i(a), .b_i(b), .sub_i(sub), .sat_i(sat),
        .out_valid_o(outValid2), .out_ready_i(outReady),
        .y_o(y2), .carry_out_o(cOut2), .ovf_o(ovf2)
    );

    // Independent reference: 33-bit unsigned sum for the carry, wide signed sum for overflow.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms, input logic mt);
        logic [32:0] u;
        longint      sr;
        logic        o;
        logic [31:0] r;
        u  = ms ? ({1'b0, ma} + {1'b0, ~mb} + 33'd1) : ({1'b0, ma} + {1'b0, mb});
        sr = ms ? (longint'($signed(ma)) - longint'($signed(mb)))
                : (longint'($signed(ma)) + longint'($signed(mb)));
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r  = u[31:0];
        if (mt && o) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {o, u[32], r};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                 input logic vs, input logic vt);
        @(negedge clk);
        inValid = 1'b1; a = va; b = vb; sub = vs; sat = vt;
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        check("latency_early", {33'd0, outValid}, 34'd0);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] ey,
                               input logic ec, input logic eo);
        check({tag, "_valid"},  {33'd0, outValid},  34'd1);
        check({tag, "_res"},    {ovf, cOut, y},     {eo, ec, ey});
        check({tag, "_valid2"}, {33'd0, outValid2}, 34'd1);
        check({tag, "_res2"},   {ovf2, cOut2, y2},  {eo, ec, ey});
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic        ss [8];
    logic        st [8];
    logic [33:0] expQ [$];
    logic [33:0] held;
    logic [33:0] front;
    bit          stallPrev;
    bit          sawValid;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst = 1'b1; inValid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_valid", {33'd0, outValid}, 34'd0);
        check("reset_res",   {ovf, cOut, y},    34'd0);

        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        checkOutput("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        checkOutput("add_sat", 32'h7FFF_FFFF, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        checkOutput("sub_sat", 32'h8000_0000, 1'b1, 1'b1);
        applyStimulus(32'd5, 32'd7, 1'b1, 1'b0);
        checkOutput("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(32'd7, 32'd5, 1'b1, 1'b0);
        checkOutput("sub_pos", 32'd2, 1'b1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        checkOutput("ripple", 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom; sb[i] = $urandom;
            ss[i] = 1'($urandom_range(1)); st[i] = 1'($urandom_range(1));
        end
        sa[0] = 32'h7FFF_FFF0; sb[0] = 32'h0000_0100; ss[0] = 1'b0; st[0] = 1'b1;
        sent = 0; got = 0; cyc = 0; stallPrev = 0; held = '0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            outReady = (cyc % 2) == 1;
            if (sent < 8) begin
                inValid = 1'b1; a = sa[sent]; b = sb[sent]; sub = ss[sent]; sat = st[sent];
            end else begin
                inValid = 1'b0;
            end
            #1;
            check("in_ready",  {33'd0, inReady},  {33'd0, !(outValid && !outReady)});
            check("in_ready2", {33'd0, inReady2}, {33'd0, !(outValid2 && !outReady)});
            if (stallPrev) check("stall_hold", {ovf, cOut, y} ^ {34{!outValid}}, held);
            if (outValid && outReady) begin
                front = (expQ.size() > 0) ? expQ.pop_front() : ~34'd0 ^ {ovf, cOut, y};
                check("stream_res",  {ovf, cOut, y},    front);
                check("stream_res2", {ovf2, cOut2, y2}, front);
                got++;
            end
            stallPrev = outValid && !outReady;
            if (stallPrev) held = {ovf, cOut, y};
            if (inValid && inReady) begin
                expQ.push_back(model(a, b, sub, sat));
                sent++;
            end
        end
        check("stream_count", 34'(got), 34'd8);
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b1;
        repeat (6) @(negedge clk);

        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; sat = 1'b0; inValid = 1'b1;
        @(negedge clk);
        a = 32'h3333_3333;
        @(negedge clk);
        a = 32'h4444_4444;
        @(negedge clk);
        rst = 1'b1; a = 32'h5555_5555;
        @(negedge clk);
        rst = 1'b0; inValid = 1'b0;
        check("midrst_valid", {33'd0, outValid}, 34'd0);
        check("midrst_res",   {ovf, cOut, y},    34'd0);
        sawValid = 0;
        repeat (8) begin
            @(negedge clk);
            if (outValid || outValid2) sawValid = 1;
        end
        check("midrst_flushed", {33'd0, sawValid}, 34'd0);
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
        checkOutput("post_rst", 32'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
